hamming_tx: RTL and testbench

HAMMING_TX -- requirements
Module: hamming_tx

---
 rtl/hamming_tx_pkg.sv | 15 +
 rtl/hamming_tx_encode.sv | 24 ++
 rtl/hamming_tx.sv | 115 +++++++++++
 tb/tb_hamming_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_tx_pkg.sv
// Shared constants and types for the Hamming(12,8) serial transmitter.
package hamming_tx_pkg;
   localparam int CODE_W = 12;
   localparam int DATA_W = 8;

   // Parity sits at the power-of-two positions (1-based 1,2,4,8).
   localparam int PAR_POS [4] = '{0, 1, 3, 7};
   localparam int DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;
endpackage

// File: rtl/hamming_tx_encode.sv
// Combinational Hamming(12,8) encoder with optional single-bit error injection.
module hamming_encode
   import hamming_tx_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [3:0]        inject_pos,
   output logic [CODE_W-1:0] code
);
   logic [CODE_W-1:0] raw;
   logic [CODE_W-1:0] flip;

   always_comb begin
      raw = '0;
      for (int i = 0; i < DATA_W; i++) raw[DATA_POS[i]] = data[i];
      raw[PAR_POS[0]] = raw[2] ^ raw[4] ^ raw[6] ^ raw[8] ^ raw[10];
      raw[PAR_POS[1]] = raw[2] ^ raw[5] ^ raw[6] ^ raw[9] ^ raw[10];
      raw[PAR_POS[2]] = raw[4] ^ raw[5] ^ raw[6] ^ raw[11];
      raw[PAR_POS[3]] = raw[8] ^ raw[9] ^ raw[10] ^ raw[11];
      // Flip after parity so the decoder's syndrome equals inject_pos.
      flip = '0;
      if (inject_pos >= 4'd1 && inject_pos <= 4'd12) flip[4'(inject_pos - 4'd1)] = 1'b1;
      code = raw ^ flip;
   end
endmodule

// File: rtl/hamming_tx.sv
// Hamming(12,8) transmitter: one-entry buffer, LSB-first serializer, optional inter-frame gap.
module hamming_tx
   import hamming_tx_pkg::*;
#(
   parameter int GAP_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  inject_pos,
   output logic        ser_out,
   output logic        ser_valid,
   output logic        ser_start,
   output logic [15:0] frames_sent
);
   localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t            state;
   logic [CODE_W-1:0] enc_word;
   logic [CODE_W-1:0] buf_word;
   logic [CODE_W-1:0] shifter;
   logic              buf_full;
   logic [3:0]        bit_cnt;
   logic [3:0]        gap_cnt;
   logic [15:0]       frames_cnt;
   logic              accept;
   logic              last_bit;
   logic              gap_done;
   logic              load;

   hamming_encode u_enc (
      .data       (in_data),
      .inject_pos (inject_pos),
      .code       (enc_word)
   );

   assign accept   = in_valid & ~buf_full;
   assign last_bit = (state == ST_SHIFT) && (bit_cnt == 4'd11);
   assign gap_done = (state == ST_GAP) && (gap_cnt == GAP_LAST);
   // The last gap cycle hands straight to SHIFT so the idle run is exactly GAP_CYCLES.
   assign load     = buf_full && ((state == ST_IDLE) || gap_done ||
                                  (last_bit && (GAP_CYCLES == 0)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         buf_full <= 1'b0;
         buf_word <= '0;
      end else if (accept) begin
         buf_full <= 1'b1;
         buf_word <= enc_word;
      end else if (load) begin
         buf_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         shifter    <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         frames_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  shifter <= buf_word;
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (last_bit) begin
                  frames_cnt <= frames_cnt + 16'd1;
                  bit_cnt    <= '0;
                  if (GAP_CYCLES > 0) begin
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end else if (load) begin
                     shifter <= buf_word;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  shifter <= shifter >> 1;
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
            ST_GAP: begin
               if (gap_done) begin
                  gap_cnt <= '0;
                  if (load) begin
                     shifter <= buf_word;
                     bit_cnt <= '0;
                     state   <= ST_SHIFT;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready    = ~buf_full;
   assign ser_valid   = (state == ST_SHIFT);
   assign ser_out     = ser_valid & shifter[0];
   assign ser_start   = ser_valid && (bit_cnt == 4'd0);
   assign frames_sent = frames_cnt;
endmodule

// File: tb/tb_hamming_tx.sv
// Bench for hamming_tx: directed and random frames against a positional Hamming model.
module tb_hamming_tx;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  a_data, b_data;
   logic        a_valid, b_valid;
   logic [3:0]  a_inj, b_inj;
   logic        a_ready, b_ready;
   logic        a_so, a_sv, a_ss, b_so, b_sv, b_ss;
   logic [15:0] a_fs, b_fs;

   int          checks = 0;
   int          errors = 0;
   logic [11:0] cap_q[$];
   int          runs_q[$];
   int          gaps_q[$];
   logic [15:0] exp_frames;

   always #5 clk = ~clk;

   hamming_tx #(.GAP_CYCLES(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
      .inject_pos(a_inj), .ser_out(a_so), .ser_valid(a_sv), .ser_start(a_ss), .frames_sent(a_fs));

   hamming_tx #(.GAP_CYCLES(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
      .inject_pos(b_inj), .ser_out(b_so), .ser_valid(b_sv), .ser_start(b_ss), .frames_sent(b_fs));

   // Reference: data fills non-power-of-two 1-based positions, each parity covers positions sharing its bit.
   function automatic logic [11:0] ref_code(input logic [7:0] d, input logic [3:0] inj);
      logic [12:1] h;
      int k;
      logic x;
      h = '0;
      k = 0;
      for (int p = 1; p <= 12; p++)
         if ((p & (p - 1)) != 0) begin h[p] = d[k]; k++; end
      for (int pp = 1; pp <= 8; pp = pp * 2) begin
         x = 1'b0;
         for (int p = 1; p <= 12; p++)
            if ((p & pp) != 0 && p != pp) x = x ^ h[p];
         h[pp] = x;
      end
      if (inj >= 1 && inj <= 12) h[int'(inj)] = ~h[int'(inj)];
      return h;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send(input int sel, input logic [7:0] d, input logic [3:0] inj, input bit hold);
      bit done;
      done = 1'b0;
      if (sel == 0) begin a_data = d; a_inj = inj; a_valid = 1'b1; end
      else          begin b_data = d; b_inj = inj; b_valid = 1'b1; end
      for (int t = 0; t < 200 && !done; t++) begin
         if ((sel == 0) ? a_ready : b_ready) done = 1'b1;
         @(negedge clk);
      end
      chk("send_handshake", {31'd0, done}, 32'd1);
      if (done) chk("ready_low_when_full", {31'd0, (sel == 0) ? a_ready : b_ready}, 32'd0);
      if (!hold) begin
         if (sel == 0) begin a_valid = 1'b0; a_data = 8'($urandom); a_inj = 4'($urandom); end
         else          begin b_valid = 1'b0; b_data = 8'($urandom); b_inj = 4'($urandom); end
      end
   endtask

   task automatic wait_frame(output logic [11:0] w);
      bit got;
      got = 1'b0;
      w = '0;
      for (int t = 0; t < 300 && !got; t++) begin
         if (cap_q.size() > 0) begin w = cap_q.pop_front(); got = 1'b1; end
         else @(negedge clk);
      end
      chk("frame_arrived", {31'd0, got}, 32'd1);
   endtask

   task automatic run_one(input logic [7:0] d, input logic [3:0] inj);
      logic [11:0] w;
      send(0, d, inj, 1'b0);
      wait_frame(w);
      chk($sformatf("code_d%02h_i%0d", d, inj), {20'd0, w}, {20'd0, ref_code(d, inj)});
      @(negedge clk);
      exp_frames = exp_frames + 16'd1;
      chk("frames_sent", {16'd0, a_fs}, {16'd0, exp_frames});
   endtask

   // Serial capture for the no-gap instance.
   initial begin
      int          idx;
      int          run;
      logic [11:0] word;
      idx = 0; run = 0; word = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            idx = 0; run = 0;
         end else if (a_sv) begin
            checks++;
            assert (a_ss === (idx == 0)) else begin
               errors++;
               $error("FAIL ser_start_pos got=%b bit=%0d", a_ss, idx);
            end
            word[idx] = a_so;
            idx++; run++;
            if (idx == 12) begin cap_q.push_back(word); idx = 0; end
         end else begin
            checks++;
            assert (a_so === 1'b0) else begin
               errors++;
               $error("FAIL ser_out_idle got=%b exp=0", a_so);
            end
            if (run != 0) begin runs_q.push_back(run); run = 0; end
         end
      end
   end

   // Idle-run measurement between frames for the gapped instance.
   initial begin
      int idle;
      bit seen;
      idle = 0; seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            idle = 0; seen = 1'b0;
         end else if (b_sv) begin
            if (b_ss && seen) gaps_q.push_back(idle);
            idle = 0; seen = 1'b1;
         end else begin
            idle++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] w;
      logic [7:0]  rd;
      logic [3:0]  ri;
      logic [7:0]  vals [3];
      bit          ok;

      reset_n = 1'b0;
      a_valid = 1'b0; a_data = '0; a_inj = '0;
      b_valid = 1'b0; b_data = '0; b_inj = '0;
      exp_frames = '0;
      repeat (2) @(negedge clk);
      chk("rst_ser_valid", {31'd0, a_sv}, 32'd0);
      chk("rst_ser_start", {31'd0, a_ss}, 32'd0);
      chk("rst_ser_out", {31'd0, a_so}, 32'd0);
      chk("rst_frames", {16'd0, a_fs}, 32'd0);
      chk("rst_in_ready", {31'd0, a_ready}, 32'd1);
      reset_n = 1'b1;
      @(negedge clk);

      // First frame: latency of one edge from handshake to code[0].
      send(0, 8'h00, 4'd0, 1'b0);
      chk("lat_idle_after_e0", {31'd0, a_sv}, 32'd0);
      @(negedge clk);
      chk("lat_valid_after_e1", {31'd0, a_sv}, 32'd1);
      chk("lat_start_after_e1", {31'd0, a_ss}, 32'd1);
      wait_frame(w);
      chk("code_00", {20'd0, w}, 32'h000);
      @(negedge clk);
      exp_frames = 16'd1;
      chk("frames_one", {16'd0, a_fs}, 32'd1);

      run_one(8'hFF, 4'd0);
      chk("ref_ff", {20'd0, ref_code(8'hFF, 4'd0)}, 32'hF77);
      run_one(8'hA5, 4'd5);
      chk("ref_a5_i5", {20'd0, ref_code(8'hA5, 4'd5)}, 32'hA37);
      run_one(8'hA5, 4'd14);
      chk("ref_a5_i14", {20'd0, ref_code(8'hA5, 4'd14)}, 32'hA27);
      run_one(8'hA5, 4'd12);
      run_one(8'h5A, 4'd1);

      for (int i = 0; i < 16; i++) begin
         rd = 8'($urandom);
         ri = 4'($urandom_range(0, 15));
         run_one(rd, ri);
      end

      // Back-to-back with in_valid held high: one 36-cycle valid run.
      repeat (3) @(negedge clk);
      runs_q.delete();
      cap_q.delete();
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      for (int i = 0; i < 3; i++) send(0, vals[i], 4'd0, (i < 2));
      for (int i = 0; i < 3; i++) begin
         wait_frame(w);
         chk($sformatf("b2b_code%0d", i), {20'd0, w}, {20'd0, ref_code(vals[i], 4'd0)});
      end
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         if (runs_q.size() > 0) ok = 1'b1;
         else @(negedge clk);
      end
      chk("b2b_run_seen", {31'd0, ok}, 32'd1);
      if (ok) chk("b2b_run_len", runs_q[0], 32'd36);
      @(negedge clk);
      exp_frames = exp_frames + 16'd3;
      chk("b2b_frames", {16'd0, a_fs}, {16'd0, exp_frames});

      // Gapped instance: exactly three idle cycles between frames.
      gaps_q.delete();
      vals[0] = 8'h44; vals[1] = 8'h55; vals[2] = 8'h66;
      for (int i = 0; i < 3; i++) send(1, vals[i], 4'd0, (i < 2));
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         if (gaps_q.size() >= 2 && b_fs == 16'd3) ok = 1'b1;
         else @(negedge clk);
      end
      chk("gap_done", {31'd0, ok}, 32'd1);
      if (gaps_q.size() >= 2) begin
         chk("gap_len0", gaps_q[0], 32'd3);
         chk("gap_len1", gaps_q[1], 32'd3);
      end
      chk("gap_frames", {16'd0, b_fs}, 32'd3);

      // Reset during bit 6 with a second byte buffered.
      repeat (3) @(negedge clk);
      send(0, 8'h3C, 4'd0, 1'b0);
      send(0, 8'hC3, 4'd0, 1'b0);
      repeat (5) @(negedge clk);
      chk("pre_rst_valid", {31'd0, a_sv}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, a_sv}, 32'd0);
      chk("mid_rst_out", {31'd0, a_so}, 32'd0);
      chk("mid_rst_frames", {16'd0, a_fs}, 32'd0);
      chk("mid_rst_ready", {31'd0, a_ready}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      exp_frames = '0;
      cap_q.delete();
      repeat (30) @(negedge clk);
      chk("rst_no_frame", cap_q.size(), 32'd0);
      chk("rst_frames_zero", {16'd0, a_fs}, 32'd0);
      run_one(8'h96, 4'd7);

      // Counter wrap.
      repeat (3) @(negedge clk);
      force dut_a.frames_cnt = 16'hFFFF;
      @(negedge clk);
      release dut_a.frames_cnt;
      @(negedge clk);
      chk("preload_ffff", {16'd0, a_fs}, 32'hFFFF);
      exp_frames = 16'hFFFF;
      run_one(8'h0F, 4'd0);
      chk("wrap_zero", {16'd0, a_fs}, 32'h0000);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
